// File: rtl/reset_cond_pkg.sv
// p1v_reset_pkg: shared FSM state encoding and reset-cause codes for reset_cond.
package p1v_reset_pkg;
    typedef enum logic [1:0] {POR, RUN, HOLD, STRETCH} state_t;
    localparam logic [1:0] CAUSE_POWER = 2'b00;
    localparam logic [1:0] CAUSE_TACT  = 2'b01;
    localparam logic [1:0] CAUSE_PLUG  = 2'b10;
    localparam logic [1:0] CAUSE_BOTH  = 2'b11;
    function automatic logic [1:0] cause_of(input logic tact_act, input logic plug_act);
        return (tact_act ? CAUSE_TACT : CAUSE_POWER) | (plug_act ? CAUSE_PLUG : CAUSE_POWER);
    endfunction
endpackage

// File: rtl/reset_cond_if.sv
// reset_cond_if: raw reset sources in, conditioned reset out.
// The cause/cause_cnt signals exist only when RESET_CAUSE_EN is defined.
interface reset_cond_if;
    logic       tact_resn;
    logic       plug_resn;
    logic       out_resn;
`ifdef RESET_CAUSE_EN
    logic [1:0] cause;
    logic [7:0] cause_cnt;
    modport master(output tact_resn, plug_resn, input out_resn, cause, cause_cnt);
    modport slave(input tact_resn, plug_resn, output out_resn, cause, cause_cnt);
`else
    modport master(output tact_resn, plug_resn, input out_resn);
    modport slave(input tact_resn, plug_resn, output out_resn);
`endif
endinterface

// File: rtl/reset_cond_pin_filter.sv
// pin_filter: 2-flop synchroniser plus stability counter for one active-low pin.
// RELEASE_FILTER=0 lets a high sample release the request at once.
module pin_filter #(
    parameter int CYCLES         = 16,
    parameter bit RELEASE_FILTER = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_req
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
    logic          r_s1, r_s2, r_req;
    logic [CW-1:0] r_cnt;
    logic          w_accept;
    assign w_accept = (r_cnt == LAST) || (!RELEASE_FILTER && r_s2);
    assign o_req    = r_req;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1  <= 1'b1;
            r_s2  <= 1'b1;
            r_req <= 1'b1;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_req) r_cnt <= '0;
            else if (w_accept) begin
                r_req <= r_s2;
                r_cnt <= '0;
            end else r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/reset_cond.sv
// reset_cond: merges debounced switch and filtered plug resets into one stretched reset.
// Define RESET_CAUSE_EN to add the cause/cause_cnt reporting registers.
module reset_cond
    import p1v_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1600000,
    parameter int PLUG_MIN_CYCLES = 16,
    parameter int STRETCH_CYCLES  = 160000
) (
    input logic         clock_160,
    input logic         resn,
    reset_cond_if.slave bus
);
    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [SW-1:0] TERM = SW'(STRETCH_CYCLES - 1);
    logic          w_tact_req, w_plug_req, w_req, w_term;
    state_t        r_state, w_state_next;
    logic [SW-1:0] r_cnt, w_cnt_next;
    logic          r_out_resn;
    pin_filter #(.CYCLES(DEBOUNCE_CYCLES), .RELEASE_FILTER(1'b1)) u_tact (
        .clk(clock_160), .rst_n(resn), .i_raw(bus.tact_resn), .o_req(w_tact_req)
    );
    pin_filter #(.CYCLES(PLUG_MIN_CYCLES), .RELEASE_FILTER(1'b0)) u_plug (
        .clk(clock_160), .rst_n(resn), .i_raw(bus.plug_resn), .o_req(w_plug_req)
    );
    assign w_req        = !w_tact_req || !w_plug_req;
    assign w_term       = r_cnt == TERM;
    assign bus.out_resn = r_out_resn;
    always_ff @(posedge clock_160 or negedge resn) begin
        if (!resn) begin
            r_state    <= POR;
            r_cnt      <= '0;
            r_out_resn <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_out_resn <= w_state_next == RUN;
        end
    end
    // The stretch counter only runs in POR and STRETCH; every other path clears it.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
            POR:     if (w_term) w_state_next = w_req ? HOLD : RUN;
                     else w_cnt_next = r_cnt + 1'b1;
            RUN:     if (w_req) w_state_next = HOLD;
            HOLD:    if (!w_req) w_state_next = STRETCH;
            STRETCH: if (w_req) w_state_next = HOLD;
                     else if (w_term) w_state_next = RUN;
                     else w_cnt_next = r_cnt + 1'b1;
        endcase
    end
`ifdef RESET_CAUSE_EN
    logic [1:0] r_cause, w_cause;
    logic [7:0] r_cause_cnt;
    assign w_cause       = cause_of(!w_tact_req, !w_plug_req);
    assign bus.cause     = r_cause;
    assign bus.cause_cnt = r_cause_cnt;
    always_ff @(posedge clock_160 or negedge resn) begin
        if (!resn) begin
            r_cause     <= CAUSE_POWER;
            r_cause_cnt <= '0;
        end else if (r_state == RUN && w_req) begin
            r_cause <= w_cause;
            if (r_cause_cnt != 8'hff) r_cause_cnt <= r_cause_cnt + 1'b1;
        end else if (r_state == HOLD || r_state == STRETCH) r_cause <= r_cause | w_cause;
    end
`endif
endmodule
